// File: rtl/fifo_bus_sel_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_bus_sel_arbiter
//
// Output-FIFO-side arbiter. One instance sits in front of each output FIFO
// and decides which frame dispatcher may write into it. Requesters are served
// round-robin. The grant is held until the owner's end-of-packet beat is
// written, until the owner withdraws its request (abort), or until the
// watchdog sees the locked packet go idle for too long (timeout).
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   bus_sel       request vector; bit x set means dispatcher x wants this FIFO
//   in_data       dispatcher beats, lane x at [x*DATA_W +: DATA_W]
//   in_valid      per-dispatcher beat valid
//   in_eop        per-dispatcher last-beat flag, qualified by in_valid
//   fifo_afull    FIFO almost full (2 or fewer free entries)
//   grant         one-hot grant toward the dispatchers, or all-zero
//   in_ready      per-dispatcher ready; only the owner's bit can be set
//   fifo_wr_en    registered FIFO write strobe
//   fifo_wr_data  registered FIFO write data
//   fifo_wr_eop   registered end-of-packet marker written with the beat
//   src_id        binary index of the owner, meaningful while grant != 0
//   pkt_abort     one-cycle pulse when a packet is aborted or times out
// ---------------------------------------------------------------------------
module fifo_bus_sel_arbiter #(
  parameter int PORT_NUM = 14,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PORT_NUM-1:0]          bus_sel,
  input  logic [PORT_NUM*DATA_W-1:0]   in_data,
  input  logic [PORT_NUM-1:0]          in_valid,
  input  logic [PORT_NUM-1:0]          in_eop,
  input  logic                         fifo_afull,
  output logic [PORT_NUM-1:0]          grant,
  output logic [PORT_NUM-1:0]          in_ready,
  output logic                         fifo_wr_en,
  output logic [DATA_W-1:0]            fifo_wr_data,
  output logic                         fifo_wr_eop,
  output logic [ID_W-1:0]              src_id,
  output logic                         pkt_abort
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(PORT_NUM - 1);
  localparam logic [ID_W:0] PORT_CNT = (ID_W+1)'(PORT_NUM);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [WD_W-1:0]     wdog;

  // Round-robin successor of an index, wrapping at PORT_NUM.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // Round-robin search: rotate the request vector so rr_ptr lands at bit 0,
  // take the lowest set bit, then map the offset back to an absolute index.
  logic [PORT_NUM-1:0] req_rot;
  logic [ID_W-1:0]     pick_off;
  logic [ID_W:0]       pick_sum;
  logic [ID_W-1:0]     pick_id;
  logic                pick_found;

  always_comb begin
    req_rot    = PORT_NUM'({bus_sel, bus_sel} >> rr_ptr);
    pick_off   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        pick_off   = ID_W'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= PORT_CNT) begin
      pick_sum = pick_sum - PORT_CNT;
    end
    pick_id = pick_sum[ID_W-1:0];
  end

  // Owner lane selected by the one-hot grant; all-zero while idle.
  logic [DATA_W-1:0] own_data;

  always_comb begin
    own_data = '0;
    for (int x = 0; x < PORT_NUM; x++) begin
      if (grant[x]) begin
        own_data = own_data | in_data[x*DATA_W +: DATA_W];
      end
    end
  end

  logic own_sel;
  logic own_eop;
  logic accept;
  logic eop_acc;
  logic drop;
  logic wd_fire;

  // Ready is withheld once the owner withdraws its request, except for an
  // eop beat: a last beat that coincides with the request going away still
  // closes the packet normally instead of aborting it.
  assign in_ready = grant & {PORT_NUM{~fifo_afull}} & (bus_sel | in_eop);

  assign own_sel = |(bus_sel & grant);
  assign own_eop = |(in_eop & grant);
  assign accept  = |(in_valid & in_ready);
  assign eop_acc = accept & own_eop;
  assign drop    = (state == BUSY) & ~own_sel & ~eop_acc;
  // Stall cycles under fifo_afull count as idle too.
  assign wd_fire = WD_EN & (state == BUSY) & ~accept & (wdog == WD_LAST);

  // Arbitration / write stage: everything below is registered once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= '0;
      src_id       <= '0;
      rr_ptr       <= '0;
      wdog         <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      fifo_wr_eop  <= 1'b0;
      pkt_abort    <= 1'b0;
    end else begin
      fifo_wr_en  <= accept;
      fifo_wr_eop <= eop_acc;
      pkt_abort   <= 1'b0;
      if (accept) begin
        fifo_wr_data <= own_data;
      end
      case (state)
        IDLE: begin
          wdog <= '0;
          if (|bus_sel) begin
            grant  <= {{(PORT_NUM-1){1'b0}}, 1'b1} << pick_id;
            src_id <= pick_id;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (eop_acc || drop || wd_fire) begin
            // Owner drops to lowest priority for the next round.
            grant     <= '0;
            rr_ptr    <= next_id(src_id);
            wdog      <= '0;
            state     <= IDLE;
            pkt_abort <= ~eop_acc;
          end else if (accept) begin
            wdog <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_bus_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_bus_sel_arbiter
//
// Directed bench for fifo_bus_sel_arbiter. The main instance uses the default
// watchdog (255); a second instance sharing the same inputs uses TIMEOUT=8 so
// the watchdog release can be observed without disturbing the long stall.
// ---------------------------------------------------------------------------
module tb_fifo_bus_sel_arbiter;

  localparam int PN = 14;
  localparam int DW = 32;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PN-1:0]     bus_sel;
  logic [PN*DW-1:0]  in_data;
  logic [PN-1:0]     in_valid;
  logic [PN-1:0]     in_eop;
  logic              fifo_afull;

  logic [PN-1:0]     grant, in_ready;
  logic              fifo_wr_en, fifo_wr_eop, pkt_abort;
  logic [DW-1:0]     fifo_wr_data;
  logic [IW-1:0]     src_id;

  logic [PN-1:0]     grant_w, in_ready_w;
  logic              wr_en_w, wr_eop_w, pkt_abort_w;
  logic [DW-1:0]     wr_data_w;
  logic [IW-1:0]     src_id_w;

  int n_cmp = 0;
  int n_fail = 0;

  fifo_bus_sel_arbiter #(.PORT_NUM(PN), .DATA_W(DW), .ID_W(IW), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .in_data(in_data),
    .in_valid(in_valid), .in_eop(in_eop), .fifo_afull(fifo_afull),
    .grant(grant), .in_ready(in_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_eop(fifo_wr_eop),
    .src_id(src_id), .pkt_abort(pkt_abort)
  );

  fifo_bus_sel_arbiter #(.PORT_NUM(PN), .DATA_W(DW), .ID_W(IW), .TIMEOUT(8)) dut_wd (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .in_data(in_data),
    .in_valid(in_valid), .in_eop(in_eop), .fifo_afull(fifo_afull),
    .grant(grant_w), .in_ready(in_ready_w), .fifo_wr_en(wr_en_w),
    .fifo_wr_data(wr_data_w), .fifo_wr_eop(wr_eop_w),
    .src_id(src_id_w), .pkt_abort(pkt_abort_w)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int x, input logic [DW-1:0] d, input logic v, input logic e);
    in_data[x*DW +: DW] = d;
    in_valid[x] = v;
    in_eop[x] = e;
  endtask

  task automatic clear_inputs();
    bus_sel = '0;
    in_valid = '0;
    in_eop = '0;
    fifo_afull = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    in_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (grant !== 14'h0) begin
      n_fail++; $display("FAIL reset_grant got=%h exp=%h", grant, 14'h0);
    end
    n_cmp++;
    if ({in_ready, fifo_wr_en, fifo_wr_data, fifo_wr_eop, src_id, pkt_abort} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%h wr=%b d=%h eop=%b id=%0d ab=%b exp all zero",
               in_ready, fifo_wr_en, fifo_wr_data, fifo_wr_eop, src_id, pkt_abort);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 14'h0 || fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle got grant=%h wr=%b exp grant=0 wr=0", grant, fifo_wr_en);
    end
  endtask

  task automatic test_round_robin();
    logic [PN-1:0] exp_g;
    int exp_id;
    bus_sel = 14'h3FFF;
    in_valid = '1;
    in_eop = '1;
    for (int x = 0; x < PN; x++) in_data[x*DW +: DW] = 32'hB000_0000 + x;
    for (int k = 0; k <= PN; k++) begin
      exp_id = k % PN;
      exp_g = 14'h1 << exp_id;
      tick();
      n_cmp++;
      if (grant !== exp_g || src_id !== IW'(exp_id)) begin
        n_fail++; $display("FAIL rr_grant[%0d] got=%h id=%0d exp=%h id=%0d", k, grant, src_id, exp_g, exp_id);
      end
      tick();
      n_cmp++;
      if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 32'hB000_0000 + exp_id ||
          fifo_wr_eop !== 1'b1 || grant !== 14'h0) begin
        n_fail++;
        $display("FAIL rr_write[%0d] got wr=%b d=%h eop=%b g=%h exp wr=1 d=%h eop=1 g=0",
                 k, fifo_wr_en, fifo_wr_data, fifo_wr_eop, grant, 32'hB000_0000 + exp_id);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] beats [3];
    beats[0] = 32'hD000_0000; beats[1] = 32'hD000_0001; beats[2] = 32'hD000_0002;
    bus_sel = 14'h0004;
    tick();
    n_cmp++;
    if (grant !== 14'h0004 || src_id !== 4'd2) begin
      n_fail++; $display("FAIL single_grant got=%h id=%0d exp=0004 id=2", grant, src_id);
    end
    for (int b = 0; b < 3; b++) begin
      set_lane(2, beats[b], 1'b1, (b == 2));
      #1;
      n_cmp++;
      if (in_ready !== 14'h0004) begin
        n_fail++; $display("FAIL single_ready[%0d] got=%h exp=0004", b, in_ready);
      end
      tick();
      n_cmp++;
      if (fifo_wr_en !== 1'b1 || fifo_wr_data !== beats[b] || fifo_wr_eop !== (b == 2)) begin
        n_fail++;
        $display("FAIL single_write[%0d] got wr=%b d=%h eop=%b exp wr=1 d=%h eop=%b",
                 b, fifo_wr_en, fifo_wr_data, fifo_wr_eop, beats[b], (b == 2));
      end
    end
    n_cmp++;
    if (grant !== 14'h0) begin
      n_fail++; $display("FAIL single_release got=%h exp=0", grant);
    end
    clear_inputs();
    tick();
    n_cmp++;
    if (fifo_wr_en !== 1'b0 || fifo_wr_eop !== 1'b0 || grant !== 14'h0) begin
      n_fail++; $display("FAIL single_after got wr=%b eop=%b g=%h exp 0/0/0", fifo_wr_en, fifo_wr_eop, grant);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] beats [4];
    for (int b = 0; b < 4; b++) beats[b] = 32'hC500_0000 + b;
    bus_sel = 14'h0020;
    tick();
    n_cmp++;
    if (grant !== 14'h0020 || src_id !== 4'd5) begin
      n_fail++; $display("FAIL bp_grant got=%h id=%0d exp=0020 id=5", grant, src_id);
    end
    set_lane(5, beats[0], 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== beats[0]) begin
      n_fail++; $display("FAIL bp_write0 got wr=%b d=%h exp wr=1 d=%h", fifo_wr_en, fifo_wr_data, beats[0]);
    end
    set_lane(5, beats[1], 1'b1, 1'b0);
    fifo_afull = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 14'h0) begin
      n_fail++; $display("FAIL bp_ready_stall got=%h exp=0", in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (fifo_wr_en !== 1'b0 || in_ready !== 14'h0 || grant !== 14'h0020) begin
        n_fail++; $display("FAIL bp_stall[%0d] got wr=%b rdy=%h g=%h exp wr=0 rdy=0 g=0020",
                           c, fifo_wr_en, in_ready, grant);
      end
    end
    fifo_afull = 1'b0;
    for (int b = 1; b < 4; b++) begin
      set_lane(5, beats[b], 1'b1, (b == 3));
      #1;
      n_cmp++;
      if (in_ready !== 14'h0020) begin
        n_fail++; $display("FAIL bp_ready[%0d] got=%h exp=0020", b, in_ready);
      end
      tick();
      n_cmp++;
      if (fifo_wr_en !== 1'b1 || fifo_wr_data !== beats[b] || fifo_wr_eop !== (b == 3)) begin
        n_fail++;
        $display("FAIL bp_write[%0d] got wr=%b d=%h eop=%b exp wr=1 d=%h eop=%b",
                 b, fifo_wr_en, fifo_wr_data, fifo_wr_eop, beats[b], (b == 3));
      end
    end
    clear_inputs();
    tick();
    n_cmp++;
    if (fifo_wr_en !== 1'b0 || grant !== 14'h0) begin
      n_fail++; $display("FAIL bp_after got wr=%b g=%h exp 0/0", fifo_wr_en, grant);
    end
  endtask

  task automatic test_abort();
    bus_sel = 14'h0080;
    tick();
    n_cmp++;
    if (grant !== 14'h0080 || src_id !== 4'd7) begin
      n_fail++; $display("FAIL abort_grant got=%h id=%0d exp=0080 id=7", grant, src_id);
    end
    for (int b = 0; b < 2; b++) begin
      set_lane(7, 32'hE700_0000 + b, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 32'hE700_0000 + b) begin
        n_fail++; $display("FAIL abort_write[%0d] got wr=%b d=%h exp wr=1 d=%h",
                           b, fifo_wr_en, fifo_wr_data, 32'hE700_0000 + b);
      end
    end
    bus_sel = 14'h0;
    set_lane(7, 32'hE700_0002, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (in_ready !== 14'h0) begin
      n_fail++; $display("FAIL abort_ready got=%h exp=0", in_ready);
    end
    tick();
    n_cmp++;
    if (pkt_abort !== 1'b1 || grant !== 14'h0 || fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_pulse got ab=%b g=%h wr=%b exp ab=1 g=0 wr=0", pkt_abort, grant, fifo_wr_en);
    end
    in_valid = '0;
    bus_sel = 14'h0184;
    tick();
    n_cmp++;
    if (pkt_abort !== 1'b0 || fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_one_shot got ab=%b wr=%b exp ab=0 wr=0", pkt_abort, fifo_wr_en);
    end
    n_cmp++;
    if (grant !== 14'h0100 || src_id !== 4'd8) begin
      n_fail++; $display("FAIL abort_next_rr got=%h id=%0d exp=0100 id=8", grant, src_id);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    bus_sel = 14'h0008;
    tick();
    n_cmp++;
    if (grant_w !== 14'h0008 || src_id_w !== 4'd3) begin
      n_fail++; $display("FAIL to_grant got=%h id=%0d exp=0008 id=3", grant_w, src_id_w);
    end
    set_lane(3, 32'h7777_0001, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (wr_en_w !== 1'b1 || wr_data_w !== 32'h7777_0001 || wr_eop_w !== 1'b0) begin
      n_fail++; $display("FAIL to_write got wr=%b d=%h eop=%b exp wr=1 d=77770001 eop=0",
                         wr_en_w, wr_data_w, wr_eop_w);
    end
    in_valid = '0;
    // Idle BUSY cycles 1..8 after the beat; release shows on the following cycle.
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      n_cmp++;
      if (grant_w !== 14'h0008 || pkt_abort_w !== 1'b0) begin
        n_fail++; $display("FAIL to_hold[%0d] got g=%h ab=%b exp g=0008 ab=0", c, grant_w, pkt_abort_w);
      end
    end
    tick();
    n_cmp++;
    if (grant_w !== 14'h0 || pkt_abort_w !== 1'b1 || in_ready_w !== 14'h0) begin
      n_fail++; $display("FAIL to_release got g=%h ab=%b rdy=%h exp g=0 ab=1 rdy=0", grant_w, pkt_abort_w, in_ready_w);
    end
    n_cmp++;
    if (grant !== 14'h0008 || pkt_abort !== 1'b0) begin
      n_fail++; $display("FAIL to_long_wdog got g=%h ab=%b exp g=0008 ab=0", grant, pkt_abort);
    end
    tick();
    n_cmp++;
    if (pkt_abort_w !== 1'b0 || wr_en_w !== 1'b0) begin
      n_fail++; $display("FAIL to_one_shot got ab=%b wr=%b exp 0/0", pkt_abort_w, wr_en_w);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bus_sel = 14'h0400;
    tick();
    n_cmp++;
    if (grant !== 14'h0400) begin
      n_fail++; $display("FAIL rm_grant got=%h exp=0400", grant);
    end
    set_lane(10, 32'hFA00_0000, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 32'hFA00_0000) begin
      n_fail++; $display("FAIL rm_write0 got wr=%b d=%h exp wr=1 d=fa000000", fifo_wr_en, fifo_wr_data);
    end
    set_lane(10, 32'hFA00_0001, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({grant, in_ready, fifo_wr_en, fifo_wr_data, fifo_wr_eop, src_id, pkt_abort} !== '0) begin
      n_fail++;
      $display("FAIL rm_async got g=%h rdy=%h wr=%b d=%h eop=%b id=%0d ab=%b exp all zero",
               grant, in_ready, fifo_wr_en, fifo_wr_data, fifo_wr_eop, src_id, pkt_abort);
    end
    in_valid = '0;
    bus_sel = 14'h1002;
    tick();
    n_cmp++;
    if (grant !== 14'h0 || fifo_wr_en !== 1'b0 || fifo_wr_eop !== 1'b0) begin
      n_fail++; $display("FAIL rm_held got g=%h wr=%b eop=%b exp 0/0/0", grant, fifo_wr_en, fifo_wr_eop);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 14'h0002 || src_id !== 4'd1 || fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL rm_first_grant got g=%h id=%0d wr=%b exp g=0002 id=1 wr=0", grant, src_id, fifo_wr_en);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule
